// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START_BIT = 2'd1,
    TX_DATA_BITS = 2'd2,
    TX_STOP_BIT  = 2'd3
  } tx_state_t;

  localparam int unsigned CLKS_PER_BIT_DEF = 62;
  localparam int unsigned FIFO_BITS_DEF    = 4;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO, 2**FIFO_BITS entries, extra pointer bit distinguishes full from empty.
module uart_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FIFO_BITS = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned DEPTH = 2 ** FIFO_BITS;
  localparam logic [FIFO_BITS:0] PTR_ONE = {{FIFO_BITS{1'b0}}, 1'b1};

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [FIFO_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_BITS:0] rd_ptr_q, rd_ptr_d;
  logic               do_push, do_pop;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[FIFO_BITS] != rd_ptr_q[FIFO_BITS]) &&
                     (wr_ptr_q[FIFO_BITS-1:0] == rd_ptr_q[FIFO_BITS-1:0]);
  assign rd_data_o = mem_q[rd_ptr_q[FIFO_BITS-1:0]];

  // Pointer advance; push and pop in the same cycle both take effect.
  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  // Pointer registers, cleared by reset to discard all contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[FIFO_BITS-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with request/ack front end and a TX FIFO.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned FIFO_BITS    = FIFO_BITS_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       stb_i,
  input  logic [7:0] data_i,
  output logic       ack_o,
  output logic       busy_o,
  output logic       uart_txd_o
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT);

  logic       pending_q, pending_d;
  logic       ack_q, ack_d;
  logic       accept;

  logic       fifo_full, fifo_empty, fifo_pop;
  logic [7:0] fifo_rd_data;

  tx_state_t  state_q, state_d;
  logic [15:0] clock_count_q, clock_count_d;
  logic [2:0] bit_index_q, bit_index_d;
  logic [7:0] shift_q, shift_d;
  logic       txd_q, txd_d;

  uart_fifo #(
    .WIDTH     (8),
    .FIFO_BITS (FIFO_BITS)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (accept),
    .wr_data_i (data_i),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Request handshake; stb_i seen during the ack cycle is the same request, not a new one.
  always_comb begin
    accept    = (stb_i | pending_q) & ~ack_q & ~fifo_full;
    ack_d     = accept;
    pending_d = accept ? 1'b0 : (pending_q | (stb_i & ~ack_q));
  end

  // Frame sequencer: next line level, bit timing and FIFO pop.
  always_comb begin
    state_d       = state_q;
    clock_count_d = clock_count_q;
    bit_index_d   = bit_index_q;
    shift_d       = shift_q;
    txd_d         = txd_q;
    fifo_pop      = 1'b0;
    case (state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          shift_d       = fifo_rd_data;
          txd_d         = 1'b0;
          bit_index_d   = '0;
          clock_count_d = 16'd1;
          state_d       = TX_START_BIT;
        end
      end
      TX_START_BIT: begin
        if (clock_count_q == BIT_LAST) begin
          txd_d         = shift_q[0];
          bit_index_d   = '0;
          clock_count_d = 16'd1;
          state_d       = TX_DATA_BITS;
        end else begin
          clock_count_d = clock_count_q + 16'd1;
        end
      end
      TX_DATA_BITS: begin
        if (clock_count_q == BIT_LAST) begin
          clock_count_d = 16'd1;
          if (bit_index_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = TX_STOP_BIT;
          end else begin
            // Line already shows shift_q[0]; shift so the next bit sits at [0].
            bit_index_d = bit_index_q + 3'd1;
            txd_d       = shift_q[1];
            shift_d     = {1'b0, shift_q[7:1]};
          end
        end else begin
          clock_count_d = clock_count_q + 16'd1;
        end
      end
      TX_STOP_BIT: begin
        if (clock_count_q == BIT_LAST) begin
          if (!fifo_empty) begin
            fifo_pop      = 1'b1;
            shift_d       = fifo_rd_data;
            txd_d         = 1'b0;
            bit_index_d   = '0;
            clock_count_d = 16'd1;
            state_d       = TX_START_BIT;
          end else begin
            txd_d   = 1'b1;
            state_d = TX_IDLE;
          end
        end else begin
          clock_count_d = clock_count_q + 16'd1;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = TX_IDLE;
      end
    endcase
  end

  // Control state, line flop and handshake registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= TX_IDLE;
      clock_count_q <= '0;
      bit_index_q   <= '0;
      txd_q         <= 1'b1;
      ack_q         <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      clock_count_q <= clock_count_d;
      bit_index_q   <= bit_index_d;
      txd_q         <= txd_d;
      ack_q         <= ack_d;
      pending_q     <= pending_d;
    end
  end

  // Shift register holds the byte in flight; its value is irrelevant when idle.
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
  end

  assign ack_o      = ack_q;
  assign uart_txd_o = txd_q;
  assign busy_o     = (state_q != TX_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: issued bytes queue up, a line monitor decodes frames and compares.
module tb_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned FB    = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stb = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ack, busy, txd;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_BITS    (FB)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .stb_i      (stb),
    .data_i     (data),
    .ack_o      (ack),
    .busy_o     (busy),
    .uart_txd_o (txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb_q[$];
  int         start_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected line samples for one frame: start 0, data LSB first, stop 1, CPB clocks each.
  function automatic logic [FRAME-1:0] frame_pattern(input logic [7:0] b);
    logic [9:0]       f;
    logic [FRAME-1:0] p;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < int'(FRAME); i++) p[i] = f[i / int'(CPB)];
    return p;
  endfunction

  // Line monitor: one sample per clock on the negedge.
  logic             mon_active = 1'b0;
  logic             mon_have = 1'b0;
  int               mon_cnt = 0;
  logic [FRAME-1:0] mon_cap;
  logic [7:0]       mon_byte;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (txd === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_cap    = '1;
        mon_cap[0] = txd;
        start_q.push_back(cyc);
        mon_have = (sb_q.size() > 0);
        check("frame_expected", {63'd0, mon_have}, 64'd1);
        if (mon_have) mon_byte = sb_q.pop_front();
      end
    end else begin
      mon_cnt++;
      mon_cap[mon_cnt] = txd;
      if (mon_cnt == int'(FRAME) - 1) begin
        mon_active = 1'b0;
        if (mon_have) check("frame", {24'd0, mon_cap}, {24'd0, frame_pattern(mon_byte)});
      end
    end
  end

  task automatic push(input logic [7:0] b, output int lat, output int ack_cyc);
    @(negedge clk);
    stb  = 1'b1;
    data = b;
    sb_q.push_back(b);
    @(negedge clk);
    stb = 1'b0;
    lat = 1;
    while (ack !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    ack_cyc = cyc;
    if (ack !== 1'b1) check("ack_timeout", {63'd0, ack}, 64'd1);
  endtask

  task automatic wait_start(input int idx, input int bound, output int s);
    int n = 0;
    while (start_q.size() <= idx && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (start_q.size() <= idx) begin
      check("start_timeout", 64'(start_q.size()), 64'(idx + 1));
      s = cyc;
    end else begin
      s = start_q[idx];
    end
  endtask

  task automatic wait_idle(input int bound, output int at);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", {63'd0, busy}, 64'd0);
    at = cyc;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int lat, ack_cyc, s, at;
    logic [9:0] a5_bits;
    logic       seen_activity;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_txd", {63'd0, txd}, 64'd1);
    check("rst_ack", {63'd0, ack}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5
    start_q.delete();
    push(8'hA5, lat, ack_cyc);
    check("a5_ack_latency", 64'(lat), 64'd1);
    @(negedge clk);
    check("a5_ack_single", {63'd0, ack}, 64'd0);
    wait_start(0, 50, s);
    check("a5_txd_fall", 64'(s - ack_cyc), 64'd1);
    a5_bits = 10'b11_0100_1010; // line order 0,1,0,1,0,0,1,0,1,1 read from bit 0 up
    for (int k = 0; k < 10; k++) begin
      wait_cyc(s + 4 * k + 2);
      check($sformatf("a5_bit%0d", k), {63'd0, txd}, {63'd0, a5_bits[k]});
    end
    wait_cyc(s + 39);
    check("a5_busy_last", {63'd0, busy}, 64'd1);
    wait_cyc(s + 40);
    check("a5_busy_done", {63'd0, busy}, 64'd0);

    // Back-to-back 0x00, 0xFF
    repeat (3) @(negedge clk);
    start_q.delete();
    push(8'h00, lat, ack_cyc);
    push(8'hFF, lat, ack_cyc);
    wait_start(1, 100, s);
    check("b2b_gap", 64'(start_q[1] - start_q[0]), 64'd40);
    wait_idle(200, at);
    check("b2b_total", 64'(at - start_q[0]), 64'd80);

    // Full FIFO while a frame holds the line
    repeat (3) @(negedge clk);
    start_q.delete();
    push(8'h5A, lat, ack_cyc);
    wait_start(0, 50, s);
    for (int i = 1; i <= 16; i++) begin
      push(8'(i), lat, ack_cyc);
      check($sformatf("fill_ack%0d", i), 64'(lat), 64'd1);
    end
    push(8'h11, lat, ack_cyc);
    check("full_ack_after_pop", 64'(ack_cyc - s), 64'd41);
    wait_idle(1200, at);
    check("full_frames", 64'(start_q.size()), 64'd18);

    // Push on the exact cycle of a pop
    repeat (3) @(negedge clk);
    start_q.delete();
    push(8'h21, lat, ack_cyc);
    push(8'h22, lat, ack_cyc);
    wait_start(0, 50, s);
    wait_cyc(s + 39);
    stb  = 1'b1;
    data = 8'h23;
    sb_q.push_back(8'h23);
    @(negedge clk);
    stb = 1'b0;
    check("pushpop_ack", {63'd0, ack}, 64'd1);
    wait_idle(300, at);
    check("pushpop_frames", 64'(start_q.size()), 64'd3);

    // Reset in the middle of data bit 3 of 0x3C, with another byte queued
    repeat (3) @(negedge clk);
    start_q.delete();
    push(8'h3C, lat, ack_cyc);
    push(8'h77, lat, ack_cyc);
    wait_start(0, 50, s);
    wait_cyc(s + 17);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("rst_mid_txd", {63'd0, txd}, 64'd1);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    check("rst_mid_ack", {63'd0, ack}, 64'd0);
    rst_n = 1'b1;
    seen_activity = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0 || txd !== 1'b1) seen_activity = 1'b1;
    end
    check("rst_no_residual", {63'd0, seen_activity}, 64'd0);

    // Pointer wrap: 40 sequential bytes
    start_q.delete();
    for (int i = 0; i < 40; i++) push(8'(8'h40 + i), lat, ack_cyc);
    wait_idle(2500, at);
    check("wrap_frames", 64'(start_q.size()), 64'd40);

    repeat (5) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("line_idle", {63'd0, txd}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
